uart_rx_fifo: RTL and testbench

Serial UART receiver with a small byte FIFO, sitting directly upstream of the j4 SoC's UART0 read port. It turns the asynchronous `rx` pin into 8N1 bytes, buffers them, and exposes them as `valid`/`data`. It also accepts the one-cycle pop strobe the core raises when it reads I/O address bit 12. This decouples line-rate arrival from Forth `key` polling, which samples `valid` through misc.in bit 1.

---
 rtl/uart_rx_fifo.sv | 184 ++++++++++++++++++
 tb/tb_uart_rx_fifo.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver feeding a 2^DEPTH_LOG2-byte FIFO, with sticky overrun and framing flags.
// The head byte is read combinationally so the core can sample it in the same cycle it pops.
module uart_rx_fifo #(
    parameter int DIV        = 104,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic       clk,
    input  logic       resetq,
    input  logic       rx,
    input  logic       rd,
    input  logic       clr_err,
    output logic       valid,
    output logic [7:0] data,
    output logic       overrun,
    output logic       frame_err
);

    localparam int DIVW  = $clog2(DIV);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DIVW-1:0]       DIV_HALF = DIVW'(DIV / 2 - 1);
    localparam logic [DIVW-1:0]       DIV_FULL = DIVW'(DIV - 1);
    localparam logic [DEPTH_LOG2:0]   CNT_FULL = (DEPTH_LOG2 + 1)'(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } state_t;

    logic                  rx_meta_r;
    logic                  rx_s_r;
    state_t                state_r;
    state_t                state_s;
    logic [DIVW-1:0]       div_r;
    logic [DIVW-1:0]       div_s;
    logic [2:0]            bit_cnt_r;
    logic [2:0]            bit_cnt_s;
    logic [7:0]            shift_r;
    logic [7:0]            shift_s;
    logic                  push_s;
    logic                  ferr_set_s;

    logic [7:0]            mem_r [DEPTH];
    logic [DEPTH_LOG2-1:0] wptr_r;
    logic [DEPTH_LOG2-1:0] rptr_r;
    logic [DEPTH_LOG2:0]   count_r;
    logic [DEPTH_LOG2:0]   count_s;
    logic                  full_s;
    logic                  pop_s;
    logic                  push_ok_s;
    logic                  ovr_set_s;
    logic                  overrun_r;
    logic                  frame_err_r;

    // Receiver next-state: samples mid-bit using a divider counted down from the start edge.
    always_comb begin
        state_s    = state_r;
        div_s      = div_r;
        bit_cnt_s  = bit_cnt_r;
        shift_s    = shift_r;
        push_s     = 1'b0;
        ferr_set_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (!rx_s_r) begin
                    state_s = ST_START;
                    div_s   = DIV_HALF;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_START: begin
                if (div_r == {DIVW{1'b0}}) begin
                    if (!rx_s_r) begin
                        state_s   = ST_DATA;
                        div_s     = DIV_FULL;
                        bit_cnt_s = 3'd0;
                    end else begin
                        state_s = ST_IDLE;
                    end
                end else begin
                    div_s = div_r - 1'b1;
                end
            end
            ST_DATA: begin
                if (div_r == {DIVW{1'b0}}) begin
                    shift_s   = {rx_s_r, shift_r[7:1]};
                    div_s     = DIV_FULL;
                    bit_cnt_s = bit_cnt_r + 1'b1;
                    if (bit_cnt_r == 3'd7) begin
                        state_s = ST_STOP;
                    end else begin
                        state_s = ST_DATA;
                    end
                end else begin
                    div_s = div_r - 1'b1;
                end
            end
            ST_STOP: begin
                if (div_r == {DIVW{1'b0}}) begin
                    state_s    = ST_IDLE;
                    push_s     = rx_s_r;
                    ferr_set_s = ~rx_s_r;
                end else begin
                    div_s = div_r - 1'b1;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // FIFO control: a push into a full FIFO survives only if a pop frees the head slot this cycle.
    always_comb begin
        full_s    = (count_r == CNT_FULL);
        pop_s     = rd && valid;
        push_ok_s = push_s && (!full_s || pop_s);
        ovr_set_s = push_s && full_s && !pop_s;
        if (push_ok_s && !pop_s) begin
            count_s = count_r + 1'b1;
        end else if (pop_s && !push_ok_s) begin
            count_s = count_r - 1'b1;
        end else begin
            count_s = count_r;
        end
    end

    // Synchronizer, receiver, FIFO pointers and sticky flags.
    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            rx_meta_r   <= 1'b1;
            rx_s_r      <= 1'b1;
            state_r     <= ST_IDLE;
            div_r       <= {DIVW{1'b0}};
            bit_cnt_r   <= 3'd0;
            shift_r     <= 8'h00;
            wptr_r      <= {DEPTH_LOG2{1'b0}};
            rptr_r      <= {DEPTH_LOG2{1'b0}};
            count_r     <= {(DEPTH_LOG2 + 1){1'b0}};
            overrun_r   <= 1'b0;
            frame_err_r <= 1'b0;
        end else begin
            rx_meta_r <= rx;
            rx_s_r    <= rx_meta_r;
            state_r   <= state_s;
            div_r     <= div_s;
            bit_cnt_r <= bit_cnt_s;
            shift_r   <= shift_s;
            count_r   <= count_s;
            if (push_ok_s) begin
                wptr_r <= wptr_r + 1'b1;
            end
            if (pop_s) begin
                rptr_r <= rptr_r + 1'b1;
            end
            // Set events take priority over a same-cycle clear.
            if (ovr_set_s) begin
                overrun_r <= 1'b1;
            end else if (clr_err) begin
                overrun_r <= 1'b0;
            end
            if (ferr_set_s) begin
                frame_err_r <= 1'b1;
            end else if (clr_err) begin
                frame_err_r <= 1'b0;
            end
        end
    end

    // Byte storage; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_r[wptr_r] <= shift_r;
        end
    end

    assign valid     = (count_r != {(DEPTH_LOG2 + 1){1'b0}});
    assign data      = valid ? mem_r[rptr_r] : 8'h00;
    assign overrun   = overrun_r;
    assign frame_err = frame_err_r;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench for uart_rx_fifo at DIV=16, depth 16: bytes expected are queued as frames
// are sent and compared against the head as the bench pops them.
module tb_uart_rx_fifo;

    localparam int DIV     = 16;
    localparam int DEPTH   = 16;
    localparam int PUSH_AT = 2 + DIV / 2 + 9 * DIV;

    logic       clk = 1'b0;
    logic       resetq = 1'b0;
    logic       rx = 1'b1;
    logic       rd = 1'b0;
    logic       clr_err = 1'b0;
    logic       valid;
    logic [7:0] data;
    logic       overrun;
    logic       frame_err;

    int         n_cmp = 0;
    int         n_err = 0;
    int         rise_at;
    logic [7:0] exp_q[$];

    uart_rx_fifo #(.DIV(DIV), .DEPTH_LOG2(4)) dut (
        .clk(clk), .resetq(resetq), .rx(rx), .rd(rd), .clr_err(clr_err),
        .valid(valid), .data(data), .overrun(overrun), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    // Drive one 10-bit frame from negedges. rd_at pulses rd on that cycle index (checking the
    // head first); rst_at asserts reset at that index and abandons the frame.
    task automatic send_frame(input logic [7:0] b, input logic stop_bit, input int rd_at, input int rst_at);
        logic [9:0] bits;
        logic       was_valid;
        logic [7:0] hd;
        bits    = {stop_bit, b, 1'b0};
        rise_at = -1;
        @(negedge clk);
        was_valid = valid;
        for (int i = 0; i < 10 * DIV; i++) begin
            if (i > 0) @(negedge clk);
            if (!was_valid && valid && rise_at < 0) rise_at = i;
            if (i == rst_at) begin
                resetq = 1'b0;
                rx     = 1'b1;
                rd     = 1'b0;
                return;
            end
            if (i > 0 && (i % DIV) == 0) bits = bits >> 1;
            rx = bits[0];
            if (i == rd_at) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL pop_in_frame: got data %h with empty scoreboard", data);
                end else begin
                    hd = exp_q.pop_front();
                    if (data !== hd) begin
                        n_err++;
                        $display("FAIL pop_in_frame: got %h expected %h", data, hd);
                    end
                end
                rd = 1'b1;
            end else begin
                rd = 1'b0;
            end
        end
        @(negedge clk);
        rx = 1'b1;
        rd = 1'b0;
        if (stop_bit && exp_q.size() < DEPTH) exp_q.push_back(b);
    endtask

    // Check the head against the scoreboard, then pop it with a one-cycle rd.
    task automatic read_byte();
        logic [7:0] hd;
        n_cmp++;
        if (valid !== 1'b1) begin
            n_err++;
            $display("FAIL read_valid: got %b expected 1", valid);
        end
        n_cmp++;
        if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL read_data: got %h with empty scoreboard", data);
        end else begin
            hd = exp_q.pop_front();
            if (data !== hd) begin
                n_err++;
                $display("FAIL read_data: got %h expected %h", data, hd);
            end
        end
        rd = 1'b1;
        @(negedge clk);
        rd = 1'b0;
    endtask

    task automatic check_idle_outputs(input string name, input logic exp_valid, input logic exp_ovr, input logic exp_ferr);
        n_cmp++;
        if (valid !== exp_valid || overrun !== exp_ovr || frame_err !== exp_ferr ||
            (!exp_valid && data !== 8'h00)) begin
            n_err++;
            $display("FAIL %s: got valid=%b data=%h ovr=%b ferr=%b expected valid=%b ovr=%b ferr=%b",
                     name, valid, data, overrun, frame_err, exp_valid, exp_ovr, exp_ferr);
        end
    endtask

    task automatic pulse_clr();
        @(negedge clk);
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        check_idle_outputs("reset_held", 1'b0, 1'b0, 1'b0);
        resetq = 1'b1;
        repeat (4) @(negedge clk);
        check_idle_outputs("reset_released", 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_single_byte();
        send_frame(8'h55, 1'b1, -1, -1);
        n_cmp++;
        if (rise_at < PUSH_AT || rise_at > PUSH_AT + 2) begin
            n_err++;
            $display("FAIL single_latency: got %0d cycles expected %0d+-1", rise_at, PUSH_AT + 1);
        end
        read_byte();
        check_idle_outputs("single_after_pop", 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_order_wrap();
        for (int k = 0; k < 20; k++) begin
            send_frame(8'(k + 1), 1'b1, -1, -1);
            if ((k % 4) == 3) begin
                for (int j = 0; j < 4; j++) read_byte();
            end
        end
        check_idle_outputs("order_end", 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_overrun();
        for (int k = 0; k < 17; k++) send_frame(8'h40 + 8'(k), 1'b1, -1, -1);
        check_idle_outputs("overrun_set", 1'b1, 1'b1, 1'b0);
        for (int j = 0; j < 16; j++) read_byte();
        check_idle_outputs("overrun_drained", 1'b0, 1'b1, 1'b0);
        pulse_clr();
        check_idle_outputs("overrun_cleared", 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_full_push_pop();
        for (int k = 0; k < 16; k++) send_frame(8'h80 + 8'(k), 1'b1, -1, -1);
        send_frame(8'hF0, 1'b1, PUSH_AT, -1);
        check_idle_outputs("fullpp_no_overrun", 1'b1, 1'b0, 1'b0);
        for (int j = 0; j < 16; j++) read_byte();
        check_idle_outputs("fullpp_drained", 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_glitch_frame_err();
        @(negedge clk);
        rx = 1'b0;
        repeat (DIV / 4) @(negedge clk);
        rx = 1'b1;
        repeat (2 * DIV) @(negedge clk);
        check_idle_outputs("glitch_ignored", 1'b0, 1'b0, 1'b0);
        send_frame(8'h5A, 1'b1, -1, -1);
        send_frame(8'hA5, 1'b0, -1, -1);
        repeat (2 * DIV) @(negedge clk);
        check_idle_outputs("frame_err_set", 1'b1, 1'b0, 1'b1);
        read_byte();
        check_idle_outputs("frame_err_no_push", 1'b0, 1'b0, 1'b1);
        pulse_clr();
        check_idle_outputs("frame_err_cleared", 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_reset_mid_frame();
        send_frame(8'h99, 1'b1, -1, -1);
        send_frame(8'h0F, 1'b0, -1, -1);
        repeat (2 * DIV) @(negedge clk);
        check_idle_outputs("pre_reset_state", 1'b1, 1'b0, 1'b1);
        send_frame(8'hC3, 1'b1, -1, 5 * DIV);
        exp_q.delete();
        repeat (3) @(negedge clk);
        check_idle_outputs("midframe_reset_held", 1'b0, 1'b0, 1'b0);
        resetq = 1'b1;
        repeat (4) @(negedge clk);
        check_idle_outputs("midframe_reset_released", 1'b0, 1'b0, 1'b0);
        send_frame(8'h3C, 1'b1, -1, -1);
        read_byte();
        check_idle_outputs("post_reset_drained", 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_single_byte();
        test_order_wrap();
        test_overrun();
        test_full_push_pop();
        test_glitch_frame_err();
        test_reset_mid_frame();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
